// File: rtl/os_array_sequencer.sv
// Control sequencer for an output-stationary systolic array: clear, skewed feed, drain, switch, scan-out.
// Optional performance counters are compiled in with OS_ARRAY_SEQUENCER_PERF_CNT_EN.
module os_array_sequencer #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int K_WIDTH     = 16,
    parameter int STAGE       = 5,
    parameter int EXTRA_DELAY = 3,
    parameter int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [K_WIDTH-1:0] k_len,
    input  logic               stall,
    output logic               busy,
    output logic               done,
    output logic               feed_valid,
    output logic [K_WIDTH-1:0] feed_idx,
    output logic               pipeline_en,
    output logic               reg_clear,
    output logic               cell_en,
    output logic               cell_sc_en,
    output logic               c_switch,
    output logic               cscan_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ROW_W-1:0]   out_row
`ifdef OS_ARRAY_SEQUENCER_PERF_CNT_EN
    ,
    output logic [31:0]        perf_busy_cycles,
    output logic [31:0]        perf_stall_cycles
`endif
);

    localparam int CNT_W = K_WIDTH + 1;
    localparam logic [CNT_W-1:0] SKEW      = CNT_W'(ROWS + COLS - 2);
    localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(STAGE + EXTRA_DELAY);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_SWITCH,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [K_WIDTH-1:0] k_reg, k_next;
    logic [CNT_W-1:0]   f_len_reg, f_len_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [K_WIDTH-1:0] feed_idx_reg, feed_idx_next;
    logic [ROW_W-1:0]   out_row_reg, out_row_next;

    logic busy_reg, done_reg, feed_valid_reg, pipeline_en_reg, reg_clear_reg;
    logic cell_en_reg, cell_sc_en_reg, c_switch_reg, cscan_en_reg, out_valid_reg;

    logic advance;
    logic beat;
    logic next_active;

    // The registered pipeline_en marks the current cycle as advancing, so the
    // counters and the array's view of the pipeline can never disagree.
    assign advance     = pipeline_en_reg;
    assign beat        = out_valid_reg && out_ready;
    assign next_active = (state_next == S_FEED) || (state_next == S_DRAIN);

    always_comb begin
        state_next    = state_reg;
        k_next        = k_reg;
        f_len_next    = f_len_reg;
        cnt_next      = cnt_reg;
        feed_idx_next = feed_idx_reg;
        out_row_next  = out_row_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    k_next        = k_len;
                    f_len_next    = {1'b0, k_len} + SKEW;
                    cnt_next      = '0;
                    feed_idx_next = '0;
                    out_row_next  = '0;
                    state_next    = (k_len != '0) ? S_CLEAR : S_DONE;
                end
            end
            S_CLEAR: begin
                cnt_next      = '0;
                feed_idx_next = '0;
                state_next    = S_FEED;
            end
            S_FEED: begin
                if (advance) begin
                    if (feed_idx_reg < k_reg) begin
                        feed_idx_next = feed_idx_reg + 1'b1;
                    end
                    if (cnt_reg == f_len_reg - 1'b1) begin
                        cnt_next   = '0;
                        state_next = S_DRAIN;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (advance) begin
                    if (cnt_reg == DRAIN_LEN - 1'b1) begin
                        cnt_next      = '0;
                        feed_idx_next = '0;
                        state_next    = S_SWITCH;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            S_SWITCH: begin
                out_row_next = '0;
                state_next   = S_SCAN;
            end
            S_SCAN: begin
                if (beat) begin
                    if (out_row_reg == LAST_ROW) begin
                        out_row_next = '0;
                        state_next   = S_DONE;
                    end else begin
                        out_row_next = out_row_reg + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            k_reg           <= '0;
            f_len_reg       <= '0;
            cnt_reg         <= '0;
            feed_idx_reg    <= '0;
            out_row_reg     <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            feed_valid_reg  <= 1'b0;
            pipeline_en_reg <= 1'b0;
            reg_clear_reg   <= 1'b0;
            cell_en_reg     <= 1'b0;
            cell_sc_en_reg  <= 1'b0;
            c_switch_reg    <= 1'b0;
            cscan_en_reg    <= 1'b0;
            out_valid_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            k_reg           <= k_next;
            f_len_reg       <= f_len_next;
            cnt_reg         <= cnt_next;
            feed_idx_reg    <= feed_idx_next;
            out_row_reg     <= out_row_next;
            busy_reg        <= (state_next != S_IDLE);
            done_reg        <= (state_next == S_DONE);
            reg_clear_reg   <= (state_next == S_CLEAR);
            pipeline_en_reg <= (state_next == S_CLEAR) || (next_active && !stall);
            cell_en_reg     <= next_active;
            cell_sc_en_reg  <= (state_next == S_FEED);
            feed_valid_reg  <= (state_next == S_FEED) && !stall && (feed_idx_next < k_next);
            c_switch_reg    <= (state_next == S_SWITCH);
            out_valid_reg   <= (state_next == S_SCAN);
            // The scan chain shifts in the cycle after each accepted row.
            cscan_en_reg    <= (state_reg == S_SCAN) && beat;
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign feed_valid  = feed_valid_reg;
    assign feed_idx    = feed_idx_reg;
    assign pipeline_en = pipeline_en_reg;
    assign reg_clear   = reg_clear_reg;
    assign cell_en     = cell_en_reg;
    assign cell_sc_en  = cell_sc_en_reg;
    assign c_switch    = c_switch_reg;
    assign cscan_en    = cscan_en_reg;
    assign out_valid   = out_valid_reg;
    assign out_row     = out_row_reg;

`ifdef OS_ARRAY_SEQUENCER_PERF_CNT_EN
    logic [31:0] perf_busy_reg;
    logic [31:0] perf_stall_reg;

    // Stall cycles are the FEED/DRAIN cycles in which the pipeline did not advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_reg  <= '0;
            perf_stall_reg <= '0;
        end else if (state_reg == S_IDLE && start) begin
            perf_busy_reg  <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (busy_reg && (perf_busy_reg != '1)) begin
                perf_busy_reg <= perf_busy_reg + 1'b1;
            end
            if ((state_reg == S_FEED || state_reg == S_DRAIN) && !pipeline_en_reg
                && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + 1'b1;
            end
        end
    end

    assign perf_busy_cycles  = perf_busy_reg;
    assign perf_stall_cycles = perf_stall_reg;
`endif

endmodule
